bus_share_arbiter: RTL and testbench
====================================

Name: bus_share_arbiter

Overview:
- Round-robin arbiter that shares one 16-bit datapath bus among NREQ requesters.
- The bus is a MUX16-style selection of requester data words.
- Sequences each grant as a burst of VALID/READY beats, closed by LAST, a beat limit, or the requester withdrawing.
- Sits between requester blocks and the shared consumer, for example the ALU operand bus.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 16, data word width
MAX_BEATS, 16, maximum beats per grant; 0 = unlimited

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  reset, asynchronous assert, active-low
REQ  input  NREQ  per-requester bus request, level
VALID  input  NREQ  per-requester beat valid
LAST  input  NREQ  per-requester final-beat marker, qualified by VALID
D  input  NREQ*WIDTH  packed requester data; slice i = D[i*WIDTH +: WIDTH]
BUS_READY  input  1  consumer accepts beat
GNT  output  NREQ  one-hot grant, registered
READY  output  NREQ  per-requester beat accept
BUS_D  output  WIDTH  selected data
BUS_VALID  output  1  selected VALID
BUS_LAST  output  1  final beat of current grant
ABORT  output  1  one-cycle pulse: grant ended by REQ withdrawal

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset (RST_N=0, effective immediately, including mid-grant):
  - state=IDLE, GNT=0, ptr=0, beat count=0, ABORT=0.
  - READY=0, BUS_VALID=0, BUS_LAST=0, BUS_D=0.
  - An interrupted burst is lost; there is no resume.
- States: IDLE, GRANT.
- IDLE:
  - If REQ!=0, pick the first i with REQ[i]=1 searching from ptr upward, wrapping modulo NREQ.
  - At the next edge: GNT=onehot(i), count=0, go to GRANT.
  - Latency: REQ seen at edge n gives GNT high after edge n+1 — one cycle.
  - If REQ==0, stay in IDLE with GNT=0.
- GRANT, with g = granted index:
  - BUS_D=D slice g, BUS_VALID=VALID[g], READY[g]=BUS_READY. All other READY bits are 0.
  - All of these are combinational from the GNT register.
  - A beat is a cycle with VALID[g] & BUS_READY; each beat increments count.
  - BUS_LAST = BUS_VALID & (LAST[g] | (MAX_BEATS!=0 & count==MAX_BEATS-1)).
  - On a beat with BUS_LAST=1: next edge GNT=0, state=IDLE, ptr=(g+1) mod NREQ, count=0.
  - REQ[g]=0 in GRANT without a LAST beat that cycle:
    - Next edge: GNT=0, state=IDLE, ptr=(g+1) mod NREQ.
    - ABORT=1 for exactly that following cycle.
  - REQ[g]=0 in the same cycle as a LAST beat: normal completion, no ABORT.
  - Requests from other requesters are ignored until return to IDLE.
  - There is at least one idle cycle between grants. Back-to-back bursts cost one bubble.
- Fairness:
  - Requester i, held continuously, is granted within NREQ-1 other grants.
  - Each of those grants is at most MAX_BEATS beats long when MAX_BEATS!=0.
- Count width: clog2(MAX_BEATS+1); it saturates only through the LAST rule.
- Idle outputs: BUS_D=0 whenever GNT=0. No X propagation from unselected D.
- BUS_READY low stalls the burst indefinitely.
  - No timeout other than REQ withdrawal.
  - VALID[g] may toggle freely.

Decomposition:
- Shared package:
  - State encoding constants (IDLE=0, GRANT=1).
  - Default WIDTH and NREQ constants.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: REQ, ptr.
  - Outputs: one-hot pick and its index.
  - Reusable by later schedulers.
- The data select is a one-hot AND-OR over slices, the MUX16 idea generalised. It is not a separate module.

Test Plan:
1. Reset: hold RST_N=0 with REQ=4'b1111. -> GNT=0, BUS_D=0, BUS_VALID=0, ABORT=0. After release, GNT=4'b0001 one cycle later (ptr=0).
2. Single burst: REQ[2]=1, 3 beats D=16'h00A1/00A2/00A3, LAST on the 3rd, BUS_READY=1. -> BUS_D follows those values, BUS_LAST=1 only on beat 3, GNT=0 the next cycle, ptr=3.
3. Rotation: REQ=4'b1111 constantly, each burst 1 beat with LAST. -> grant order 0,1,2,3,0. One idle cycle between grants. READY only to the granted requester.
4. Beat limit: MAX_BEATS=4, REQ[1] streams VALID with LAST never set. -> BUS_LAST on the 4th beat, grant released, then requester 1 re-granted only after any other pending requester.
5. Stall and abort: granted requester 3, BUS_READY=0 for 5 cycles (BUS_VALID=1, READY[3]=0), then REQ[3] drops. -> next cycle GNT=0, ABORT=1 for exactly one cycle, ptr=0.
6. Async reset mid-burst: RST_N low between edges during beat 2 of a grant. -> GNT, READY and BUS_VALID go to 0 immediately without waiting for CLK. After release, arbitration restarts from ptr=0.

Source files
------------

// File: rtl/bus_share_arbiter_pkg.sv
// Shared types and defaults for the bus share arbiter
// and its round-robin picker.
package bus_share_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 16;

    function automatic int cnt_width(input int max_beats);
        return (max_beats == 0) ? 1 : $clog2(max_beats + 1);
    endfunction

endpackage

// File: rtl/bus_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request
// at or above ptr, wrapping modulo NREQ.
module rr_pick
    import bus_share_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] pick,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int            j;
    logic [IW-1:0] jj;

    always_comb begin
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        j    = 0;
        jj   = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            jj = IW'(j);
            if (!any && req[jj]) begin
                any      = 1'b1;
                pick[jj] = 1'b1;
                idx      = jj;
            end
        end
    end

endmodule

// File: rtl/bus_share_arbiter.sv
// Round-robin arbiter sharing one data bus among NREQ
// requesters, one VALID/READY burst per grant.
module bus_share_arbiter
    import bus_share_arbiter_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_BEATS = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [NREQ-1:0]       REQ,
    input  logic [NREQ-1:0]       VALID,
    input  logic [NREQ-1:0]       LAST,
    input  logic [NREQ*WIDTH-1:0] D,
    input  logic                  BUS_READY,
    output logic [NREQ-1:0]       GNT,
    output logic [NREQ-1:0]       READY,
    output logic [WIDTH-1:0]      BUS_D,
    output logic                  BUS_VALID,
    output logic                  BUS_LAST,
    output logic                  ABORT
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = cnt_width(MAX_BEATS);
    localparam logic [CW-1:0] LIM =
        CW'((MAX_BEATS == 0) ? 0 : MAX_BEATS - 1);
    localparam logic [IW-1:0] TOP_IDX = IW'(NREQ - 1);

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            abort_q, abort_d;

    logic [NREQ-1:0] pick;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic            sel_valid, sel_last, sel_req;
    logic            lim_hit, beat;
    logic [IW-1:0]   ptr_nxt;
    logic [WIDTH-1:0] bus_d;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req  (REQ),
        .ptr  (ptr_q),
        .pick (pick),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign sel_valid = |(VALID & gnt_q);
    assign sel_last  = |(LAST & gnt_q);
    assign sel_req   = |(REQ & gnt_q);
    assign lim_hit   = (MAX_BEATS != 0) && (cnt_q == LIM);
    assign beat      = sel_valid & BUS_READY;
    assign ptr_nxt   = (gidx_q == TOP_IDX) ? '0 : gidx_q + 1'b1;

    // AND-OR select keeps unselected (possibly X) slices off the bus
    always_comb begin
        bus_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus_d = bus_d | (D[i*WIDTH +: WIDTH] & {WIDTH{gnt_q[i]}});
        end
    end

    assign GNT       = gnt_q;
    assign READY     = gnt_q & {NREQ{BUS_READY}};
    assign BUS_D     = bus_d;
    assign BUS_VALID = sel_valid;
    assign BUS_LAST  = sel_valid & (sel_last | lim_hit);
    assign ABORT     = abort_q;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        abort_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    gnt_d   = pick;
                    gidx_d  = pick_idx;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (beat && BUS_LAST) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = ptr_nxt;
                    cnt_d   = '0;
                end else if (!sel_req) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = ptr_nxt;
                    cnt_d   = '0;
                    abort_d = 1'b1;
                end else if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
        end
    end

endmodule

// File: tb/tb_bus_share_arbiter.sv
// Directed self-checking bench for bus_share_arbiter
// with NREQ=4, WIDTH=16, MAX_BEATS=4.
module tb_bus_share_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 16;

    logic                  CLK = 1'b0;
    logic                  RST_N;
    logic [NREQ-1:0]       REQ;
    logic [NREQ-1:0]       VALID;
    logic [NREQ-1:0]       LAST;
    logic [NREQ*WIDTH-1:0] D;
    logic                  BUS_READY;
    logic [NREQ-1:0]       GNT;
    logic [NREQ-1:0]       READY;
    logic [WIDTH-1:0]      BUS_D;
    logic                  BUS_VALID;
    logic                  BUS_LAST;
    logic                  ABORT;

    int checks = 0;
    int errors = 0;

    bus_share_arbiter #(
        .NREQ      (NREQ),
        .WIDTH     (WIDTH),
        .MAX_BEATS (4)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .REQ       (REQ),
        .VALID     (VALID),
        .LAST      (LAST),
        .D         (D),
        .BUS_READY (BUS_READY),
        .GNT       (GNT),
        .READY     (READY),
        .BUS_D     (BUS_D),
        .BUS_VALID (BUS_VALID),
        .BUS_LAST  (BUS_LAST),
        .ABORT     (ABORT)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        REQ       = '0;
        VALID     = '0;
        LAST      = '0;
        BUS_READY = 1'b0;
        RST_N     = 1'b0;
        #2;
        RST_N     = 1'b1;
    endtask

    task automatic test_reset();
        RST_N     = 1'b0;
        REQ       = 4'b1111;
        VALID     = 4'b1111;
        LAST      = 4'b0000;
        BUS_READY = 1'b1;
        D         = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        tick();
        tick();
        checks++;
        if (GNT !== 4'b0000) begin
            errors++;
            $display("FAIL rst_gnt got %b want 0000", GNT);
        end
        checks++;
        if (BUS_D !== 16'h0000) begin
            errors++;
            $display("FAIL rst_bus_d got %h want 0000", BUS_D);
        end
        checks++;
        if (BUS_VALID !== 1'b0 || ABORT !== 1'b0 || READY !== 4'b0000) begin
            errors++;
            $display("FAIL rst_outs got v=%b a=%b r=%b want 0 0 0000",
                     BUS_VALID, ABORT, READY);
        end
        RST_N = 1'b1;
        tick();
        checks++;
        if (GNT !== 4'b0001) begin
            errors++;
            $display("FAIL rst_first_gnt got %b want 0001", GNT);
        end
        checks++;
        if (BUS_D !== 16'h1111) begin
            errors++;
            $display("FAIL rst_first_d got %h want 1111", BUS_D);
        end
        do_reset();
    endtask

    task automatic test_single_burst();
        logic [15:0] vals [3];
        vals[0] = 16'h00A1;
        vals[1] = 16'h00A2;
        vals[2] = 16'h00A3;
        D   = '0;
        REQ = 4'b0100;
        tick();
        checks++;
        if (GNT !== 4'b0100) begin
            errors++;
            $display("FAIL sb_gnt got %b want 0100", GNT);
        end
        VALID     = 4'b0100;
        BUS_READY = 1'b1;
        for (int k = 0; k < 3; k++) begin
            D[2*WIDTH +: WIDTH] = vals[k];
            LAST = (k == 2) ? 4'b0100 : 4'b0000;
            #1;
            checks++;
            if (BUS_D !== vals[k] || BUS_LAST !== (k == 2)
                || READY !== 4'b0100) begin
                errors++;
                $display("FAIL sb_beat%0d got d=%h l=%b r=%b want d=%h l=%b r=0100",
                         k, BUS_D, BUS_LAST, READY, vals[k], (k == 2));
            end
            tick();
        end
        REQ   = 4'b0000;
        VALID = 4'b0000;
        LAST  = 4'b0000;
        checks++;
        if (GNT !== 4'b0000 || ABORT !== 1'b0 || BUS_D !== 16'h0000) begin
            errors++;
            $display("FAIL sb_end got g=%b a=%b d=%h want 0000 0 0000",
                     GNT, ABORT, BUS_D);
        end
        REQ = 4'b1111;
        tick();
        checks++;
        if (GNT !== 4'b1000) begin
            errors++;
            $display("FAIL sb_ptr3 got %b want 1000", GNT);
        end
        do_reset();
    endtask

    task automatic test_rotation();
        logic [3:0] order [5];
        order[0] = 4'b0001;
        order[1] = 4'b0010;
        order[2] = 4'b0100;
        order[3] = 4'b1000;
        order[4] = 4'b0001;
        D         = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
        REQ       = 4'b1111;
        VALID     = 4'b1111;
        LAST      = 4'b1111;
        BUS_READY = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (GNT !== order[k] || READY !== order[k] || BUS_LAST !== 1'b1) begin
                errors++;
                $display("FAIL rot%0d got g=%b r=%b l=%b want g=r=%b l=1",
                         k, GNT, READY, BUS_LAST, order[k]);
            end
            tick();
            checks++;
            if (GNT !== 4'b0000 || READY !== 4'b0000) begin
                errors++;
                $display("FAIL rot_idle%0d got g=%b r=%b want 0000",
                         k, GNT, READY);
            end
        end
        checks++;
        if (BUS_D !== 16'h0000) begin
            errors++;
            $display("FAIL rot_idle_d got %h want 0000", BUS_D);
        end
        do_reset();
    endtask

    task automatic test_beat_limit();
        REQ       = 4'b0110;
        VALID     = 4'b0010;
        LAST      = 4'b0000;
        BUS_READY = 1'b1;
        tick();
        checks++;
        if (GNT !== 4'b0010) begin
            errors++;
            $display("FAIL bl_gnt got %b want 0010", GNT);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (BUS_LAST !== (k == 3)) begin
                errors++;
                $display("FAIL bl_last%0d got %b want %b",
                         k, BUS_LAST, (k == 3));
            end
            tick();
        end
        checks++;
        if (GNT !== 4'b0000 || ABORT !== 1'b0) begin
            errors++;
            $display("FAIL bl_release got g=%b a=%b want 0000 0", GNT, ABORT);
        end
        tick();
        checks++;
        if (GNT !== 4'b0100 || BUS_VALID !== 1'b0) begin
            errors++;
            $display("FAIL bl_other got g=%b v=%b want 0100 0", GNT, BUS_VALID);
        end
        REQ = 4'b0010;
        tick();
        checks++;
        if (GNT !== 4'b0000 || ABORT !== 1'b1) begin
            errors++;
            $display("FAIL bl_abort got g=%b a=%b want 0000 1", GNT, ABORT);
        end
        tick();
        checks++;
        if (GNT !== 4'b0010 || ABORT !== 1'b0) begin
            errors++;
            $display("FAIL bl_regrant got g=%b a=%b want 0010 0", GNT, ABORT);
        end
        do_reset();
    endtask

    task automatic test_stall_abort();
        D   = {16'hBEEF, 16'h0, 16'h0, 16'h0};
        REQ = 4'b1000;
        tick();
        VALID     = 4'b1000;
        BUS_READY = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (GNT !== 4'b1000 || BUS_VALID !== 1'b1 || READY !== 4'b0000
                || BUS_D !== 16'hBEEF) begin
                errors++;
                $display("FAIL stall%0d got g=%b v=%b r=%b d=%h want 1000 1 0000 beef",
                         k, GNT, BUS_VALID, READY, BUS_D);
            end
            tick();
        end
        REQ = 4'b0000;
        tick();
        checks++;
        if (GNT !== 4'b0000 || ABORT !== 1'b1) begin
            errors++;
            $display("FAIL sa_abort got g=%b a=%b want 0000 1", GNT, ABORT);
        end
        REQ = 4'b1111;
        tick();
        checks++;
        if (ABORT !== 1'b0 || GNT !== 4'b0001) begin
            errors++;
            $display("FAIL sa_after got a=%b g=%b want 0 0001", ABORT, GNT);
        end
        do_reset();
    endtask

    task automatic test_async_reset();
        D         = {16'h0, 16'h00C2, 16'h0, 16'h0};
        REQ       = 4'b0010;
        VALID     = 4'b0010;
        LAST      = 4'b0010;
        BUS_READY = 1'b1;
        tick();
        tick();
        REQ   = 4'b0100;
        VALID = 4'b0100;
        LAST  = 4'b0000;
        tick();
        checks++;
        if (GNT !== 4'b0100 || BUS_D !== 16'h00C2) begin
            errors++;
            $display("FAIL ar_gnt got g=%b d=%h want 0100 00c2", GNT, BUS_D);
        end
        tick();
        #2;
        RST_N = 1'b0;
        #1;
        checks++;
        if (GNT !== 4'b0000 || READY !== 4'b0000 || BUS_VALID !== 1'b0
            || BUS_D !== 16'h0000) begin
            errors++;
            $display("FAIL ar_async got g=%b r=%b v=%b d=%h want 0 0 0 0",
                     GNT, READY, BUS_VALID, BUS_D);
        end
        REQ = 4'b1111;
        tick();
        RST_N = 1'b1;
        tick();
        checks++;
        if (GNT !== 4'b0001) begin
            errors++;
            $display("FAIL ar_restart got %b want 0001", GNT);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_rotation();
        test_beat_limit();
        test_stall_abort();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
